// File: rtl/ifu_fq_if.sv
`timescale 1ns/1ps
// ifu_fq_if: bundle of the fetch stage's bus signals.
//   ID side   : i_id_ready, if_to_id_valid, if_to_id_pc, if_to_id_inst
//   EX/ID ctl : bjp_stall, bjp_taken, bjp_target
//   SRAM side : inst_sram_en, inst_sram_addr, inst_sram_rdata
//   debug     : fq_count (queue occupancy, CNT_W bits)
// master = the fetch stage, slave = its surroundings (ID, EX, SRAM).
interface ifu_fq_if #(
  parameter int FQ_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic             i_id_ready;
  logic             if_to_id_valid;
  logic [31:0]      if_to_id_pc;
  logic [31:0]      if_to_id_inst;
  logic             bjp_stall;
  logic             bjp_taken;
  logic [31:0]      bjp_target;
  logic             inst_sram_en;
  logic [31:0]      inst_sram_addr;
  logic [31:0]      inst_sram_rdata;
  logic [CNT_W-1:0] fq_count;

  modport master (
    input  i_id_ready, bjp_stall, bjp_taken, bjp_target, inst_sram_rdata,
    output if_to_id_valid, if_to_id_pc, if_to_id_inst,
           inst_sram_en, inst_sram_addr, fq_count
  );

  modport slave (
    output i_id_ready, bjp_stall, bjp_taken, bjp_target, inst_sram_rdata,
    input  if_to_id_valid, if_to_id_pc, if_to_id_inst,
           inst_sram_en, inst_sram_addr, fq_count
  );
endinterface

// File: rtl/ifu_fq.sv
`timescale 1ns/1ps
// ifu_fq: instruction-fetch stage with a decoupling fetch queue.
// Keeps the fetch PC and a single outstanding SRAM request; returned
// instructions are queued with their PCs so fetch keeps running while ID
// back-pressures. Redirects flush the queue and drop the landing response.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ifu_fq_if.master (ID handshake, redirect/stall, SRAM, fq_count)
module ifu_fq #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fq_if.master    bus
);
  localparam int AW    = $clog2(FQ_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [31:0]      r_fetch_pc;
  logic             r_vld_p1;
  logic [31:0]      r_pc_p1;
  logic [CNT_W-1:0] r_count;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [31:0]      r_q_pc   [FQ_DEPTH];
  logic [31:0]      r_q_inst [FQ_DEPTH];

  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [31:0]      w_addr;
  logic [CNT_W:0]   w_credit;
  logic [CNT_W:0]   w_need;

  // Head is forced invalid during a redirect so nothing is popped while
  // the queue is being flushed.
  assign w_valid  = (r_count != '0) & ~bus.bjp_taken;
  assign w_pop    = w_valid & bus.i_id_ready;
  assign w_push   = r_vld_p1 & ~bus.bjp_taken;

  // Credits count queued entries plus the outstanding request, so a
  // response always finds a free slot when it lands.
  assign w_credit = {1'b0, r_count} + {{CNT_W{1'b0}}, r_vld_p1};
  assign w_need   = w_credit - {{CNT_W{1'b0}}, w_pop};
  assign w_issue  = ~rst & ~bus.bjp_stall &
                    (bus.bjp_taken | (w_need < (CNT_W+1)'(FQ_DEPTH)));
  assign w_addr   = bus.bjp_taken ? bus.bjp_target : r_fetch_pc;

  assign bus.inst_sram_en   = w_issue;
  assign bus.inst_sram_addr = w_addr;

  // ---- p0 -> p1: request issue, one request in flight ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= w_issue;
      if (w_issue)
        r_fetch_pc <= w_addr + 32'd4;
      else if (bus.bjp_taken)
        r_fetch_pc <= bus.bjp_target;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue)
      r_pc_p1 <= w_addr;
  end

  // ---- p1 -> queue: response lands, queue control ----
  always_ff @(posedge clk) begin
    if (rst || bus.bjp_taken) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_q_pc[r_wr_ptr]   <= r_pc_p1;
      r_q_inst[r_wr_ptr] <= bus.inst_sram_rdata;
    end
  end

  // Head is read straight from queue registers; data zeroed when invalid.
  assign bus.if_to_id_valid = w_valid;
  assign bus.if_to_id_pc    = w_valid ? r_q_pc[r_rd_ptr]   : 32'd0;
  assign bus.if_to_id_inst  = w_valid ? r_q_inst[r_rd_ptr] : 32'd0;
  assign bus.fq_count       = r_count;
endmodule

// File: tb/tb_ifu_fq.sv
`timescale 1ns/1ps
module tb_ifu_fq;
  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam int          DEPTH  = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  ifu_fq_if #(.FQ_DEPTH(DEPTH)) bus ();

  ifu_fq #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model: inst = addr, returned the cycle after the request.
  always @(posedge clk)
    bus.inst_sram_rdata <= bus.inst_sram_en ? bus.inst_sram_addr : 32'hdeadbeef;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Leaves the bench at the start of cycle 0 with rst released.
  task automatic hold_reset();
    rst = 1'b1;
    bus.i_id_ready = 1'b0;
    bus.bjp_stall  = 1'b0;
    bus.bjp_taken  = 1'b0;
    bus.bjp_target = 32'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_id_ready = 1'b1;
    bus.bjp_stall  = 1'b0;
    bus.bjp_taken  = 1'b0;
    bus.bjp_target = 32'd0;
    step();
    step();
    mid();
    n_tests++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.if_to_id_valid); end
    n_tests++; if (bus.if_to_id_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus.if_to_id_pc); end
    n_tests++; if (bus.if_to_id_inst !== 32'd0) begin n_fail++; $display("FAIL reset_inst got %h want 0", bus.if_to_id_inst); end
    n_tests++; if (bus.inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", bus.inst_sram_en); end
    n_tests++; if (bus.fq_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.fq_count); end
    step();
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    hold_reset();
    bus.i_id_ready = 1'b1;
    exp = RST_PC;
    for (int cyc = 0; cyc < 12; cyc++) begin
      mid();
      if (cyc == 0) begin
        n_tests++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL stream_first_req en=%b addr=%h want 1 %h", bus.inst_sram_en, bus.inst_sram_addr, RST_PC); end
      end
      if (cyc < 2) begin
        n_tests++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency cyc%0d valid=%b want 0", cyc, bus.if_to_id_valid); end
      end else begin
        n_tests++; if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== exp) begin n_fail++; $display("FAIL stream_pc cyc%0d valid=%b pc=%h want %h", cyc, bus.if_to_id_valid, bus.if_to_id_pc, exp); end
        n_tests++; if (bus.if_to_id_inst !== exp) begin n_fail++; $display("FAIL stream_inst cyc%0d got %h want %h", cyc, bus.if_to_id_inst, exp); end
        exp = exp + 32'd4;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    hold_reset();
    bus.i_id_ready = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      mid();
      n_tests++; if (bus.fq_count > 3'(DEPTH)) begin n_fail++; $display("FAIL bp_overflow cyc%0d count=%0d", cyc, bus.fq_count); end
      if (cyc >= 5) begin
        n_tests++; if (bus.inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL bp_en cyc%0d got %b want 0", cyc, bus.inst_sram_en); end
        n_tests++; if (bus.fq_count !== 3'(DEPTH)) begin n_fail++; $display("FAIL bp_full cyc%0d got %0d want %0d", cyc, bus.fq_count, DEPTH); end
      end
      step();
    end
    bus.i_id_ready = 1'b1;
    exp = RST_PC;
    for (int k = 0; k < 10; k++) begin
      mid();
      if (k == 0) begin
        n_tests++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC + 32'h10) begin n_fail++; $display("FAIL bp_refill en=%b addr=%h want 1 %h", bus.inst_sram_en, bus.inst_sram_addr, RST_PC + 32'h10); end
      end
      n_tests++; if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== exp) begin n_fail++; $display("FAIL bp_drain k%0d valid=%b pc=%h want %h", k, bus.if_to_id_valid, bus.if_to_id_pc, exp); end
      exp = exp + 32'd4;
      step();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp;
    hold_reset();
    bus.i_id_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) step();
    bus.bjp_taken  = 1'b1;
    bus.bjp_target = 32'h1c000100;
    bus.i_id_ready = 1'b1;
    mid();
    n_tests++; if (bus.fq_count !== 3'd3) begin n_fail++; $display("FAIL redir_pre_count got %0d want 3", bus.fq_count); end
    n_tests++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c000100) begin n_fail++; $display("FAIL redir_req en=%b addr=%h want 1 1c000100", bus.inst_sram_en, bus.inst_sram_addr); end
    n_tests++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid got %b want 0", bus.if_to_id_valid); end
    step();
    bus.bjp_taken = 1'b0;
    mid();
    n_tests++; if (bus.fq_count !== 3'd0 || bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush count=%0d valid=%b want 0 0", bus.fq_count, bus.if_to_id_valid); end
    step();
    exp = 32'h1c000100;
    for (int k = 0; k < 6; k++) begin
      mid();
      n_tests++; if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== exp) begin n_fail++; $display("FAIL redir_stream k%0d valid=%b pc=%h want %h", k, bus.if_to_id_valid, bus.if_to_id_pc, exp); end
      exp = exp + 32'd4;
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    int pops;
    hold_reset();
    bus.i_id_ready = 1'b1;
    exp = RST_PC;
    pops = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.bjp_stall = (cyc >= 5 && cyc <= 7);
      mid();
      if (bus.bjp_stall) begin
        n_tests++; if (bus.inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL stall_en cyc%0d got %b want 0", cyc, bus.inst_sram_en); end
      end
      if (cyc == 7) begin
        n_tests++; if (bus.if_to_id_valid !== 1'b0 || bus.fq_count !== 3'd0) begin n_fail++; $display("FAIL stall_drain valid=%b count=%0d want 0 0", bus.if_to_id_valid, bus.fq_count); end
      end
      if (cyc == 8) begin
        n_tests++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC + 32'h14) begin n_fail++; $display("FAIL stall_resume en=%b addr=%h want 1 %h", bus.inst_sram_en, bus.inst_sram_addr, RST_PC + 32'h14); end
      end
      if (bus.if_to_id_valid === 1'b1) begin
        n_tests++; if (bus.if_to_id_pc !== exp || bus.if_to_id_inst !== exp) begin n_fail++; $display("FAIL stall_seq cyc%0d pc=%h inst=%h want %h", cyc, bus.if_to_id_pc, bus.if_to_id_inst, exp); end
        exp = exp + 32'd4;
        pops++;
      end
      step();
    end
    bus.bjp_stall = 1'b0;
    n_tests++; if (pops != 9) begin n_fail++; $display("FAIL stall_pop_count got %0d want 9", pops); end
  endtask

  task automatic test_redirect_stall();
    hold_reset();
    bus.i_id_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) step();
    bus.bjp_taken  = 1'b1;
    bus.bjp_stall  = 1'b1;
    bus.bjp_target = 32'h1c000200;
    mid();
    n_tests++; if (bus.inst_sram_en !== 1'b0 || bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rs_same en=%b valid=%b want 0 0", bus.inst_sram_en, bus.if_to_id_valid); end
    step();
    bus.bjp_taken = 1'b0;
    mid();
    n_tests++; if (bus.fq_count !== 3'd0 || bus.inst_sram_en !== 1'b0 || bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rs_flush count=%0d en=%b valid=%b want 0 0 0", bus.fq_count, bus.inst_sram_en, bus.if_to_id_valid); end
    step();
    bus.bjp_stall = 1'b0;
    mid();
    n_tests++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1c000200) begin n_fail++; $display("FAIL rs_first_req en=%b addr=%h want 1 1c000200", bus.inst_sram_en, bus.inst_sram_addr); end
    step();
    mid();
    n_tests++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rs_gap valid=%b want 0", bus.if_to_id_valid); end
    step();
    mid();
    n_tests++; if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== 32'h1c000200) begin n_fail++; $display("FAIL rs_target valid=%b pc=%h want 1 1c000200", bus.if_to_id_valid, bus.if_to_id_pc); end
    step();
  endtask

  task automatic test_midrun_reset();
    hold_reset();
    bus.i_id_ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) step();
    rst = 1'b1;
    step();
    mid();
    n_tests++; if (bus.if_to_id_valid !== 1'b0 || bus.if_to_id_pc !== 32'd0 || bus.if_to_id_inst !== 32'd0) begin n_fail++; $display("FAIL mr_head valid=%b pc=%h inst=%h want 0", bus.if_to_id_valid, bus.if_to_id_pc, bus.if_to_id_inst); end
    n_tests++; if (bus.inst_sram_en !== 1'b0 || bus.fq_count !== 3'd0) begin n_fail++; $display("FAIL mr_ctl en=%b count=%0d want 0 0", bus.inst_sram_en, bus.fq_count); end
    step();
    rst = 1'b0;
    bus.i_id_ready = 1'b1;
    mid();
    n_tests++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== RST_PC) begin n_fail++; $display("FAIL mr_restart en=%b addr=%h want 1 %h", bus.inst_sram_en, bus.inst_sram_addr, RST_PC); end
    step();
    step();
    mid();
    n_tests++; if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== RST_PC) begin n_fail++; $display("FAIL mr_first valid=%b pc=%h want 1 %h", bus.if_to_id_valid, bus.if_to_id_pc, RST_PC); end
    step();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    hold_reset();
    bus.i_id_ready = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) step();
    bus.bjp_taken  = 1'b1;
    bus.bjp_target = 32'hfffffff8;
    mid();
    n_tests++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_valid got %b want 0", bus.if_to_id_valid); end
    step();
    bus.bjp_taken = 1'b0;
    mid();
    n_tests++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_gap got %b want 0", bus.if_to_id_valid); end
    step();
    exp = 32'hfffffff8;
    for (int k = 0; k < 4; k++) begin
      mid();
      n_tests++; if (bus.if_to_id_valid !== 1'b1 || bus.if_to_id_pc !== exp || bus.if_to_id_inst !== exp) begin n_fail++; $display("FAIL wrap_seq k%0d valid=%b pc=%h inst=%h want %h", k, bus.if_to_id_valid, bus.if_to_id_pc, bus.if_to_id_inst, exp); end
      exp = exp + 32'd4;
      step();
    end
  endtask

  // Reference model: ID must see a gap-free, duplicate-free program-order
  // stream starting at the most recent redirect target.
  task automatic test_random();
    logic [31:0] exp;
    logic [31:0] t;
    logic        quiet1;
    logic        quiet2;
    hold_reset();
    exp    = RST_PC;
    quiet1 = 1'b0;
    quiet2 = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.i_id_ready = ($urandom_range(0, 9) < 7);
      bus.bjp_stall  = ($urandom_range(0, 9) == 0);
      bus.bjp_taken  = ($urandom_range(0, 29) == 0);
      t = $urandom();
      bus.bjp_target = t & 32'hfffffffc;
      mid();
      n_tests++; if (bus.fq_count > 3'(DEPTH)) begin n_fail++; $display("FAIL rnd_overflow cyc%0d count=%0d", cyc, bus.fq_count); end
      if (bus.bjp_taken) begin
        n_tests++; if (bus.if_to_id_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_valid cyc%0d got %b want 0", cyc, bus.if_to_id_valid); end
        exp = bus.bjp_target;
      end else begin
        if (bus.if_to_id_valid === 1'b1 && bus.i_id_ready) begin
          n_tests++; if (bus.if_to_id_pc !== exp || bus.if_to_id_inst !== exp) begin n_fail++; $display("FAIL rnd_seq cyc%0d pc=%h inst=%h want %h", cyc, bus.if_to_id_pc, bus.if_to_id_inst, exp); end
          exp = exp + 32'd4;
        end
        if (quiet1 && quiet2) begin
          n_tests++; if (bus.if_to_id_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_live cyc%0d valid=%b want 1", cyc, bus.if_to_id_valid); end
        end
      end
      quiet2 = quiet1;
      quiet1 = bus.i_id_ready & ~bus.bjp_stall & ~bus.bjp_taken;
      step();
    end
    bus.bjp_taken = 1'b0;
    bus.bjp_stall = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_id_ready = 1'b0;
    bus.bjp_stall  = 1'b0;
    bus.bjp_taken  = 1'b0;
    bus.bjp_target = 32'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_stall();
    test_redirect_stall();
    test_midrun_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ifu_fq.md
# ifu_fq

Parametrised instruction-fetch stage with a decoupling fetch queue, the next generation of the single-register IF stage. It drives the synchronous instruction SRAM and keeps the PC and one-request-in-flight state. Returned instructions are buffered with their PCs in a FIFO of configurable depth, so fetch keeps running while ID back-pressures. It sits between the inst SRAM port and the ID stage, and takes branch redirect and stall from EX/ID.

## Interface
- RESET_PC, 32'h1c000000, first fetch address after reset
- FQ_DEPTH, 4, fetch-queue entries; power of two, >= 2
- CNT_W, $clog2(FQ_DEPTH)+1, width of occupancy counters (derived, do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_id_ready  in  1  ID accepts the queue head this cycle
- if_to_id_valid  out  1  queue head valid
- if_to_id_pc  out  32  PC of head; 0 when not valid
- if_to_id_inst  out  32  instruction of head; 0 when not valid
- bjp_stall  in  1  suppress new SRAM requests this cycle
- bjp_taken  in  1  redirect: flush and refetch from bjp_target
- bjp_target  in  32  redirect PC, word aligned
- inst_sram_en  out  1  SRAM read request this cycle
- inst_sram_addr  out  32  SRAM read address
- inst_sram_rdata  in  32  SRAM data, valid the cycle after the accepted request
- fq_count  out  CNT_W  current queue occupancy (debug/perf)

## Operation
- State: fetch_pc (next address to request), inflight flag with inflight_pc, FIFO of {pc, inst} with rd_ptr/wr_ptr and count.
- pop = if_to_id_valid & i_id_ready.
- credit = count + inflight.
- Issue condition: issue = !rst & !bjp_stall & (bjp_taken | (credit - pop) < FQ_DEPTH).
- inst_sram_en = issue.
- inst_sram_addr = bjp_taken ? bjp_target : fetch_pc.
- On issue, fetch_pc <= inst_sram_addr + 4. Arithmetic is 32-bit modulo; 32'hfffffffc wraps to 0.
- When bjp_taken and no issue, fetch_pc <= bjp_target.
- On issue: inflight <= 1 and inflight_pc <= inst_sram_addr. Otherwise inflight <= 0.
- Response (inflight set, no bjp_taken): push {inflight_pc, inst_sram_rdata} at wr_ptr.
- Credit rule guarantees a push never meets a full queue. Overflow is a bug; assert it in the bench.
- Redirect (bjp_taken):
  - count, rd_ptr and wr_ptr clear.
  - The response arriving this cycle is discarded.
  - if_to_id_valid is forced 0 this cycle, so no pop occurs.
- Simultaneous push and pop: count unchanged, both pointers advance.
- The queue is in program order and has no bypass; the head always comes from a register.
- bjp_stall only blocks issue. Pops and the landing of a response already in flight continue.

## Timing
- Reset values: fetch_pc = RESET_PC, inflight = 0, count = 0, rd_ptr/wr_ptr = 0.
- Reset outputs: if_to_id_valid = 0, if_to_id_pc = 0, if_to_id_inst = 0, inst_sram_en = 0, fq_count = 0.
- rst asserted mid-operation: all state returns to reset values at the next edge. An in-flight response is dropped. inst_sram_en is 0 combinationally while rst = 1.
- Fetch latency:
  - Request in cycle N.
  - Data on inst_sram_rdata in N+1, written at the end of N+1.
  - if_to_id_valid in N+2.
- After reset releases at cycle 0, RESET_PC is requested in cycle 0 and presented to ID in cycle 2.
- Throughput: one instruction per cycle while ID is ready.
- With ID stalled, the queue fills to exactly FQ_DEPTH and inst_sram_en then stays 0.
- Refill: in the cycle ID resumes, a pop frees one credit, so a request issues that same cycle.
- Redirect in cycle R with bjp_stall = 0:
  - bjp_target is requested in R.
  - It is presented to ID in R+2.
- bjp_taken & bjp_stall together: flush happens, no request, fetch_pc = bjp_target. The first request follows the first cycle with bjp_stall = 0.

## Test plan
- Reset stream: release rst with i_id_ready = 1 and a SRAM model returning inst = addr. ID sees pc 1c000000, 1c000004, 1c000008… from cycle 2, one per cycle, with if_to_id_inst == if_to_id_pc.
- Backpressure, FQ_DEPTH = 4: hold i_id_ready = 0 from cycle 2. fq_count reaches 4 and inst_sram_en stays 0 with no overflow. Release ready: 4 queued PCs drain in order, then the sequence continues without gap or duplicate.
- Redirect with in-flight data: queue at 3 and inflight = 1, pulse bjp_taken with target 1c000100. The same cycle has inst_sram_addr = 1c000100, en = 1 and valid = 0. The next cycle has fq_count = 0. Pc 1c000100 reaches ID two cycles after the pulse, and no stale PC ever appears.
- Stall: hold bjp_stall = 1 for 3 cycles mid-stream. No requests are issued. The in-flight response still enters the queue, the queue drains to empty, and fetch resumes at the next sequential PC.
- Simultaneous bjp_taken + bjp_stall + i_id_ready: flush occurs with no pop and no request. After bjp_stall drops, the first request is bjp_target.
- Mid-run reset and wrap: assert rst with the queue non-empty. All outputs are 0 the next cycle and fetch restarts at RESET_PC. Separately, redirect to fffffff8: the sequence fffffff8, fffffffc, 00000000 is presented.
